// File: rtl/axi4lite_mem_slave_if.sv
// rtl/axi4lite_mem_slave_if.sv - AXI4-Lite bus bundle between master and the memory slave
interface axi4lite_mem_slave_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_W-1:0]       awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [8*DATA_BYTES-1:0] wdata;
    logic [DATA_BYTES-1:0]   wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_W-1:0]       araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [8*DATA_BYTES-1:0] rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_mem_slave.sv
// rtl/axi4lite_mem_slave.sv - AXI4-Lite on-chip RAM slave with range, privilege and read-only checks
module axi4lite_mem_slave #(
    parameter int                DATA_BYTES = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                MEM_BYTES  = 4096,
    parameter int                RO_BYTES   = 0,
    parameter bit                PRIV_ONLY  = 1'b0
) (
    input logic                 aclk,
    input logic                 areset,
    axi4lite_mem_slave_if.slave bus
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int LSB   = $clog2(DATA_BYTES);
    localparam int WORDS = MEM_BYTES / DATA_BYTES;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] RO_LIM  = (ADDR_W+1)'(RO_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Modular subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off          = addr - BASE_ADDR;
        off[LSB-1:0] = '0;
        return off;
    endfunction

    logic [DW-1:0]         mem [WORDS];

    logic                  aw_full;
    logic [ADDR_W-1:0]     aw_addr_q;
    logic                  aw_priv_q;
    logic                  w_full;
    logic [DW-1:0]         w_data_q;
    logic [DATA_BYTES-1:0] w_strb_q;
    logic                  b_valid;
    logic [1:0]            b_resp;

    logic                  ar_full;
    logic [ADDR_W-1:0]     ar_addr_q;
    logic                  r_valid;
    logic [DW-1:0]         r_data;
    logic [1:0]            r_resp;

    logic [ADDR_W-1:0]     aw_off;
    logic [ADDR_W-1:0]     ar_off;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  commit;
    logic                  issue;
    logic [1:0]            wr_resp;
    logic                  unused_bits;

    assign aw_off      = word_offset(aw_addr_q);
    assign ar_off      = word_offset(ar_addr_q);
    assign aw_in_range = {1'b0, aw_off} < MEM_LIM;
    assign ar_in_range = {1'b0, ar_off} < MEM_LIM;
    assign commit      = aw_full && w_full && (!b_valid || bus.bready);
    assign issue       = ar_full && (!r_valid || bus.rready);

    always_comb begin
        wr_resp = RESP_OKAY;
        if (!aw_in_range) begin
            wr_resp = RESP_DECERR;
        end else if (PRIV_ONLY && !aw_priv_q) begin
            wr_resp = RESP_SLVERR;
        end else if ((RO_BYTES != 0) && ({1'b0, aw_off} < RO_LIM)) begin
            wr_resp = RESP_SLVERR;
        end
    end

    assign bus.awready = !aw_full && !areset;
    assign bus.wready  = !w_full && !areset;
    assign bus.arready = !ar_full && !areset;
    assign bus.bvalid  = b_valid;
    assign bus.bresp   = b_resp;
    assign bus.rvalid  = r_valid;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_resp;

    assign unused_bits = ^{bus.arprot, bus.awprot[2:1]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            aw_priv_q <= 1'b0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
        end else begin
            if (bus.awvalid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= bus.awaddr;
                aw_priv_q <= bus.awprot[0];
            end
            if (bus.wvalid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            // Capture and commit are exclusive: capture needs an empty slot, commit a full one.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_resp;
            end else if (b_valid && bus.bready) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive ARESET.
    always_ff @(posedge aclk) begin
        if (commit && (wr_resp == RESP_OKAY)) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (w_strb_q[i]) begin
                    mem[aw_off[LSB +: IDX_W]][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_full   <= 1'b0;
            ar_addr_q <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
        end else begin
            if (bus.arvalid && !ar_full) begin
                ar_full   <= 1'b1;
                ar_addr_q <= bus.araddr;
            end
            if (issue) begin
                ar_full <= 1'b0;
                r_valid <= 1'b1;
                r_data  <= ar_in_range ? mem[ar_off[LSB +: IDX_W]] : '0;
                r_resp  <= ar_in_range ? RESP_OKAY : RESP_DECERR;
            end else if (r_valid && bus.rready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule
